// File: rtl/hilo_div_seq.sv
// Multi-cycle restoring divider producing HI (remainder) and LO (quotient) for DIV/DIVU.
// Stalls the pipeline while running, then pulses the HI/LO write enable for one cycle.
module hilo_div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              annul_i,
  output logic              stall_req_o,
  output logic              ready_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StByZero, StRun, StDone} state_e;

  state_e            r_state;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;
  logic              r_signed;
  logic              r_neg1;
  logic              r_neg2;
  logic [CntW-1:0]   r_cnt;

  logic [DATA_W-1:0] w_abs1;
  logic [DATA_W-1:0] w_abs2;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_trial;
  logic              w_ge;
  logic              w_last;
  logic              w_done_ok;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;

  always_comb begin
    w_abs1 = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    w_abs2 = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // Partial remainder stays below the divisor, so DATA_W+1 bits hold the trial sign exactly.
    w_shift = {r_rem, r_quo[DATA_W-1]};
    w_trial = w_shift - {1'b0, r_dvs};
    w_ge    = ~w_trial[DATA_W];
    w_last  = (r_cnt == CntW'(DATA_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_signed <= 1'b0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_i && !annul_i) begin
            r_cnt <= '0;
            if (opdata2_i == '0) begin
              r_rem    <= '0;
              r_quo    <= '0;
              r_signed <= 1'b0;
              r_state  <= StByZero;
            end else begin
              r_rem    <= '0;
              r_quo    <= w_abs1;
              r_dvs    <= w_abs2;
              r_signed <= signed_i;
              r_neg1   <= opdata1_i[DATA_W-1];
              r_neg2   <= opdata2_i[DATA_W-1];
              r_state  <= StRun;
            end
          end
        end
        StByZero: begin
          r_state <= annul_i ? StIdle : StDone;
        end
        StRun: begin
          if (annul_i) begin
            r_state <= StIdle;
          end else begin
            r_rem <= w_ge ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
            r_cnt <= r_cnt + CntW'(1);
            if (w_last) r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Annul in DONE must kill the write in the same cycle, hence combinational gating.
  always_comb begin
    w_done_ok   = (r_state == StDone) && !annul_i && !rst;
    w_quo_fix   = (r_signed && (r_neg1 ^ r_neg2)) ? -r_quo : r_quo;
    w_rem_fix   = (r_signed && r_neg1) ? -r_rem : r_rem;
    stall_req_o = !rst && (((r_state == StIdle) && start_i && !annul_i) ||
                           (r_state == StByZero) || (r_state == StRun));
    ready_o     = w_done_ok;
    hilo_we_o   = w_done_ok;
    hi_o        = w_done_ok ? w_rem_fix : '0;
    lo_o        = w_done_ok ? w_quo_fix : '0;
  end

endmodule

// File: tb/tb_hilo_div_seq.sv
// Randomized and directed checks of hilo_div_seq against an arithmetic reference model.
module tb_hilo_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        stall_req_o;
  logic        ready_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_err = 0;
  int n_chk = 0;

  hilo_div_seq #(.DATA_W(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .stall_req_o(stall_req_o),
    .ready_o    (ready_o),
    .hilo_we_o  (hilo_we_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Truncating division; remainder follows the dividend sign; results taken mod 2^32.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    if (b == 0) begin
      hi = 0;
      lo = 0;
    end else if (!sg) begin
      lo = a / b;
      hi = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sg);
    logic [31:0] exp_hi, exp_lo, got_hi, got_lo;
    int stall_cnt, we_cnt, done_cyc, exp_cyc;
    logic stray;
    model(a, b, sg, exp_hi, exp_lo);
    exp_cyc   = (b == 0) ? 2 : 33;
    stall_cnt = 0;
    we_cnt    = 0;
    done_cyc  = -1;
    stray     = 1'b0;
    got_hi    = '0;
    got_lo    = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst       = 1'b0;
        start_i   = 1'b1;
        signed_i  = sg;
        opdata1_i = a;
        opdata2_i = b;
      end else if (done_cyc >= 0) begin
        start_i = 1'b0;
      end
      #1;
      if (done_cyc >= 0) begin
        check_val({tag, "_after"}, {29'd0, stall_req_o, ready_o, hilo_we_o}, 32'd0);
        break;
      end
      if (stall_req_o) stall_cnt++;
      if (hilo_we_o) we_cnt++;
      if (!ready_o && (hi_o != 0 || lo_o != 0)) stray = 1'b1;
      if (ready_o) begin
        done_cyc = k;
        got_hi   = hi_o;
        got_lo   = lo_o;
      end
    end
    if (done_cyc < 0) check_val({tag, "_timeout"}, 32'd1, 32'd0);
    check_val({tag, "_stall"}, stall_cnt, exp_cyc);
    check_val({tag, "_cyc"}, done_cyc, exp_cyc);
    check_val({tag, "_we"}, we_cnt, 32'd1);
    check_val({tag, "_stray"}, {31'd0, stray}, 32'd0);
    check_val({tag, "_lo"}, got_lo, exp_lo);
    check_val({tag, "_hi"}, got_hi, exp_hi);
  endtask

  // Starts a divide and aborts it at cycle abort_cyc, either by annul or by reset.
  task automatic do_abort(input string tag, input int abort_cyc, input logic use_rst);
    int we_cnt;
    we_cnt = 0;
    for (int k = 0; k <= abort_cyc; k++) begin
      @(negedge clk);
      start_i   = 1'b1;
      signed_i  = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      if (k == abort_cyc) begin
        if (use_rst) rst = 1'b1;
        else annul_i = 1'b1;
      end
      #1;
      if (hilo_we_o) we_cnt++;
    end
    check_val({tag, "_abort_out"}, {29'd0, ready_o, hilo_we_o, stall_req_o && use_rst}, 32'd0);
    check_val({tag, "_abort_hilo"}, hi_o | lo_o, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    check_val({tag, "_next"}, {29'd0, stall_req_o, ready_o, hilo_we_o}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (hilo_we_o || ready_o) we_cnt++;
    end
    check_val({tag, "_no_we"}, we_cnt, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst       = 1'b1;
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    annul_i   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check_val("reset_ctl", {29'd0, stall_req_o, ready_o, hilo_we_o}, 32'd0);
      check_val("reset_hilo", hi_o | lo_o, 32'd0);
    end

    do_div("u100_7", 32'd100, 32'd7, 1'b0);
    do_div("uffff_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div("div0", 32'd5, 32'd0, 1'b0);
    do_div("sdiv0", 32'hFFFF_0000, 32'd0, 1'b1);

    do_abort("annul_run", 10, 1'b0);
    do_div("after_annul", 32'd9, 32'd3, 1'b0);
    do_abort("annul_done", 33, 1'b0);
    do_abort("rst_run", 5, 1'b1);
    do_div("after_rst", 32'd1000, 32'd33, 1'b1);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 9)) - 32'd4;
        1: rb = rb >> $urandom_range(1, 31);
        default: ;
      endcase
      do_div("rand", ra, rb, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hilo_div_seq.md
# hilo_div_seq

Multi-cycle divide sequencer that produces the HI/LO result for DIV/DIVU and drives the HI/LO register write. Sits beside the EX stage: accepts a divide request, stalls the pipeline while it runs one restoring-division step per cycle, then presents remainder on HI and quotient on LO with a single-cycle write enable. Supports cancellation when the in-flight instruction is flushed.

## Interface
- DATA_W, 32, operand width; the iteration counter is sized to count 0..DATA_W.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  divide request from EX; held high by EX while the instruction is stalled.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled at acceptance.
- opdata1_i  in  DATA_W  dividend; sampled at acceptance.
- opdata2_i  in  DATA_W  divisor; sampled at acceptance.
- annul_i  in  1  flush of the in-flight instruction; aborts any operation.
- stall_req_o  out  1  pipeline stall request.
- ready_o  out  1  result valid this cycle.
- hilo_we_o  out  1  HI/LO write enable, one-cycle pulse.
- hi_o  out  DATA_W  remainder; zero unless ready_o is high.
- lo_o  out  DATA_W  quotient; zero unless ready_o is high.

## Operation
- States: IDLE, BYZERO, RUN, DONE. Reset forces IDLE; every output is 0 during and after reset until a request is accepted.
- IDLE:
  - A request is accepted when start_i=1 and annul_i=0.
  - opdata2_i==0 -> BYZERO.
  - Otherwise, latch |dividend| and |divisor|. Magnitudes are used when signed_i=1; raw values when signed_i=0.
  - Also latch signed_i and both operand sign bits, clear the counter, and go to RUN.
- BYZERO: -> DONE next edge; result forced to hi=0, lo=0.
- RUN: one restoring step per cycle.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor at DATA_W+1 bits.
  - If the trial is non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - Increment the counter. After the DATA_W-th step -> DONE.
- DONE:
  - Sign correction when signed: quotient negated if the two operand signs differ; remainder takes the dividend's sign.
  - ready_o=1. hilo_we_o=1 unless annul_i. hi_o = remainder, lo_o = quotient.
  - -> IDLE next edge unconditionally. start_i seen in DONE is the same instruction and is ignored.
- Arithmetic: results are modulo 2^DATA_W. Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- annul_i=1 in BYZERO, RUN or DONE:
  - Next state is IDLE; the result is discarded.
  - In DONE, hilo_we_o and ready_o are suppressed in that same cycle (combinational gating).
- annul_i=1 together with start_i in IDLE: no acceptance.
- rst has priority over annul_i and start_i.
- The next request is accepted only from IDLE.

## Timing
- stall_req_o is combinational:
  - 1 in IDLE when start_i and not annul_i.
  - 1 in BYZERO and in RUN.
  - 0 in DONE and otherwise.
- Normal divide, with acceptance in cycle 0:
  - RUN in cycles 1..DATA_W.
  - DONE in cycle DATA_W+1 (33 for default).
  - stall_req_o high in cycles 0..DATA_W (33 cycles); it drops in DONE so EX advances on the edge ending DONE.
- Divide by zero: acceptance in cycle 0, BYZERO in cycle 1, DONE in cycle 2. stall_req_o is high in cycles 0-1.
- Annul: stall_req_o falls combinationally in the annul cycle only in IDLE; in other states it falls the cycle after (state = IDLE).
- Back-to-back requests: the earliest next acceptance is the cycle after DONE.
- hilo_we_o never lasts more than one cycle per accepted request.
- hi_o/lo_o are 0 in every cycle where ready_o=0.

## Test plan
- Reset: hold rst for 2 cycles with start_i=1, opdata=100/7 -> stall_req_o=0, ready_o=0, hilo_we_o=0, hi_o=lo_o=0. Release -> request accepted on the next cycle.
- Unsigned 100/7:
  - stall_req_o high for exactly 33 cycles.
  - In cycle 33: ready_o=1, hilo_we_o=1 (single pulse), lo_o=14, hi_o=2.
  - Also check 0xFFFFFFFF/1 -> lo_o=0xFFFFFFFF, hi_o=0.
- Signed cases:
  - -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
  - 7/-2 -> lo_o=0xFFFFFFFD, hi_o=1.
  - 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
  - Same operands with signed_i=0 -> lo_o=0, hi_o=0x80000000.
- Divide by zero 5/0 -> stall for 2 cycles; cycle 2 has ready_o=1, hilo_we_o=1, hi_o=lo_o=0.
- Annul in RUN cycle 10 -> IDLE next cycle, stall_req_o=0, no hilo_we_o. A new request 9/3 is then accepted and completes with lo_o=3, hi_o=0 after 33 cycles.
- Annul in DONE cycle and rst asserted mid-RUN -> no hilo_we_o pulse, ready_o=0, IDLE on the next edge, all outputs 0.
